// File: rtl/strobe_link_pkg.sv
// Shared definitions for the strobe-qualified one-wire data link.
//   link_state_t : transmitter FSM state encoding
//   DEF_WIDTH    : default data bits per frame
//   DEF_GAP      : default minimum idle cycles between frames
//   link_parity  : frame parity, also used by the matching receiver
package strobe_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_GAP    = 2'd3
  } link_state_t;

  localparam int DEF_WIDTH = 7;
  localparam int DEF_GAP   = 1;

  // Words are zero-extended to this width before the parity reduction.
  // Zero padding does not change the XOR, so one function serves every
  // frame width up to this limit.
  localparam int PAR_MAX_W = 64;

  function automatic logic link_parity(input logic [PAR_MAX_W-1:0] data,
                                       input logic                 odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO buffering words ahead of the serial transmitter.
//   clk, rst   : clock and asynchronous active-high reset
//   push       : write push_data (ignored while full)
//   push_data  : word to store
//   pop        : release the head word (ignored while empty)
//   pop_data   : current head word, valid while !empty
//   full/empty : occupancy flags
//   count      : words currently stored
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Guarding here keeps a full FIFO from overwriting unread data even if
  // the producer ignores the ready flag.
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/strobe_serial_tx.sv
// Serial transmitter for the strobe-qualified one-wire link.
// Words enter through a valid/ready handshake into a FIFO, then leave as
// frames: WIDTH data bits, an optional parity bit, then an idle gap.
//   clk, rst   : clock and asynchronous active-high reset
//   s_data     : word to send
//   s_valid    : s_data valid
//   s_ready    : FIFO has room
//   data_line  : serial data (registered)
//   strobe     : high on every cycle carrying a frame bit (registered)
//   frame_done : one-cycle pulse right after the last frame bit (registered)
//   fifo_count : words buffered
module strobe_serial_tx
  import strobe_link_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = 4,
  parameter int PARITY_EN  = 1,
  parameter int ODD_PARITY = 0,
  parameter int MSB_FIRST  = 1,
  parameter int GAP        = DEF_GAP
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic                       data_line,
  output logic                       strobe,
  output logic                       frame_done,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
  localparam logic [GCW-1:0] LAST_GAP = GCW'(GAP - 1);

  link_state_t      state;
  logic [BCW-1:0]   bit_cnt;
  logic [GCW-1:0]   gap_cnt;
  logic [WIDTH-1:0] shreg;
  logic             par_bit;

  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] head;
  logic             pop;

  logic             head_first;
  logic [WIDTH-1:0] head_rest;
  logic             shreg_bit;
  logic [WIDTH-1:0] shreg_next;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s_valid),
    .push_data (s_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign s_ready = ~fifo_full;

  // A frame starts from IDLE as soon as a word is waiting, or directly at
  // the end of the last gap cycle so back-to-back frames lose no cycle.
  assign pop = ~fifo_empty &
               ((state == ST_IDLE) || ((state == ST_GAP) && (gap_cnt == LAST_GAP)));

  // The first bit goes straight from the FIFO head to the output register;
  // the shift register keeps only the bits still to be sent, aligned so the
  // next one always sits at the sending end.
  always_comb begin
    head_first = 1'b0;
    head_rest  = '0;
    shreg_bit  = 1'b0;
    shreg_next = '0;
    if (MSB_FIRST != 0) begin
      head_first = head[WIDTH-1];
      head_rest  = head << 1;
      shreg_bit  = shreg[WIDTH-1];
      shreg_next = shreg << 1;
    end else begin
      head_first = head[0];
      head_rest  = head >> 1;
      shreg_bit  = shreg[0];
      shreg_next = shreg >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      shreg   <= head_rest;
      par_bit <= link_parity(PAR_MAX_W'(head), (ODD_PARITY != 0));
    end else if (state == ST_SHIFT) begin
      shreg   <= shreg_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      data_line  <= 1'b0;
      strobe     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            state     <= ST_SHIFT;
            bit_cnt   <= '0;
            data_line <= head_first;
            strobe    <= 1'b1;
          end else begin
            data_line <= 1'b0;
            strobe    <= 1'b0;
          end
        end

        // bit_cnt is the index of the bit currently on the line.
        ST_SHIFT: begin
          if (bit_cnt == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              state     <= ST_PARITY;
              data_line <= par_bit;
              strobe    <= 1'b1;
            end else begin
              state      <= ST_GAP;
              gap_cnt    <= '0;
              data_line  <= 1'b0;
              strobe     <= 1'b0;
              frame_done <= 1'b1;
            end
          end else begin
            bit_cnt   <= bit_cnt + 1'b1;
            data_line <= shreg_bit;
            strobe    <= 1'b1;
          end
        end

        ST_PARITY: begin
          state      <= ST_GAP;
          gap_cnt    <= '0;
          data_line  <= 1'b0;
          strobe     <= 1'b0;
          frame_done <= 1'b1;
        end

        ST_GAP: begin
          if (gap_cnt == LAST_GAP) begin
            if (pop) begin
              state     <= ST_SHIFT;
              bit_cnt   <= '0;
              data_line <= head_first;
              strobe    <= 1'b1;
            end else begin
              state     <= ST_IDLE;
              data_line <= 1'b0;
              strobe    <= 1'b0;
            end
          end else begin
            gap_cnt   <= gap_cnt + 1'b1;
            data_line <= 1'b0;
            strobe    <= 1'b0;
          end
        end

        default: begin
          state     <= ST_IDLE;
          data_line <= 1'b0;
          strobe    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_strobe_serial_tx.sv
// Directed bench for strobe_serial_tx: default configuration (instance a)
// and WIDTH=8 / LSB-first / odd parity / GAP=3 (instance b).
module tb_strobe_serial_tx;

  logic       clk = 1'b0;
  logic       rst;

  logic [6:0] s_data_a;
  logic       s_valid_a;
  logic       s_ready_a, data_line_a, strobe_a, frame_done_a;
  logic [2:0] fifo_count_a;

  logic [7:0] s_data_b;
  logic       s_valid_b;
  logic       s_ready_b, data_line_b, strobe_b, frame_done_b;
  logic [2:0] fifo_count_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  strobe_serial_tx dut_a (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data_a),
    .s_valid    (s_valid_a),
    .s_ready    (s_ready_a),
    .data_line  (data_line_a),
    .strobe     (strobe_a),
    .frame_done (frame_done_a),
    .fifo_count (fifo_count_a)
  );

  strobe_serial_tx #(
    .WIDTH      (8),
    .DEPTH      (4),
    .PARITY_EN  (1),
    .ODD_PARITY (1),
    .MSB_FIRST  (0),
    .GAP        (3)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data_b),
    .s_valid    (s_valid_b),
    .s_ready    (s_ready_b),
    .data_line  (data_line_b),
    .strobe     (strobe_b),
    .frame_done (frame_done_b),
    .fifo_count (fifo_count_b)
  );

  // Line monitors: capture strobed bits, strobe run/gap lengths and
  // frame_done placement, sampled on the falling edge.
  logic bits_a[$];
  logic bits_b[$];
  logic prev_a = 1'b0, seen_a = 1'b0, prev_b = 1'b0, seen_b = 1'b0;
  int   run_a = 0, run_last_a = 0, low_a = 0, gap_a = 0;
  int   fd_cnt_a = 0, fd_bad_a = 0, max_cnt_a = 0;
  int   low_b = 0, gap_b = 0, fd_cnt_b = 0;

  always @(negedge clk) begin
    if (strobe_a === 1'b1) begin
      if (!prev_a && seen_a) gap_a = low_a;
      bits_a.push_back(data_line_a);
      run_a++;
      low_a = 0;
    end else begin
      if (prev_a) begin
        run_last_a = run_a;
        run_a      = 0;
        seen_a     = 1'b1;
      end
      low_a++;
    end
    if (frame_done_a === 1'b1) begin
      fd_cnt_a++;
      if (!(prev_a && strobe_a === 1'b0)) fd_bad_a++;
    end
    if (int'(fifo_count_a) > max_cnt_a) max_cnt_a = int'(fifo_count_a);
    prev_a = (strobe_a === 1'b1);

    if (strobe_b === 1'b1) begin
      if (!prev_b && seen_b) gap_b = low_b;
      bits_b.push_back(data_line_b);
      low_b = 0;
    end else begin
      if (prev_b) seen_b = 1'b1;
      low_b++;
    end
    if (frame_done_b === 1'b1) fd_cnt_b++;
    prev_b = (strobe_b === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bits_of_a(input int start, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], bits_a[start+i]};
    return v;
  endfunction

  function automatic logic [31:0] bits_of_b(input int start, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], bits_b[start+i]};
    return v;
  endfunction

  task automatic wait_bits_a(input int need, input string tag);
    int g = 0;
    while (bits_a.size() < need && g < 300) begin
      @(negedge clk);
      g++;
    end
    check(tag, 32'(bits_a.size() >= need), 32'd1);
  endtask

  task automatic wait_bits_b(input int need, input string tag);
    int g = 0;
    while (bits_b.size() < need && g < 300) begin
      @(negedge clk);
      g++;
    end
    check(tag, 32'(bits_b.size() >= need), 32'd1);
  endtask

  logic [6:0] w [6];
  logic [7:0] wf [6];
  int         base, k, guard, fd_before;
  logic       acc, saw_full, ready_at_full;

  initial begin
    rst       = 1'b1;
    s_valid_a = 1'b0;
    s_data_a  = '0;
    s_valid_b = 1'b0;
    s_data_b  = '0;

    // Words and their hand-computed MSB-first frames (7 bits + even parity).
    w[0] = 7'b0000001; wf[0] = 8'b0000_0011;
    w[1] = 7'b1000000; wf[1] = 8'b1000_0001;
    w[2] = 7'b1111111; wf[2] = 8'b1111_1111;
    w[3] = 7'b0000000; wf[3] = 8'b0000_0000;
    w[4] = 7'b0110011; wf[4] = 8'b0110_0110;
    w[5] = 7'b1100101; wf[5] = 8'b1100_1010;

    // ---- reset state ----
    @(negedge clk);
    check("rst_s_ready",    s_ready_a,    1);
    check("rst_strobe",     strobe_a,     0);
    check("rst_data_line",  data_line_a,  0);
    check("rst_frame_done", frame_done_a, 0);
    check("rst_count",      fifo_count_a, 0);
    check("rst_b_s_ready",  s_ready_b,    1);
    rst = 1'b0;

    // ---- single frame 1010111 ----
    @(negedge clk);
    s_data_a  = 7'b1010111;
    s_valid_a = 1'b1;
    @(negedge clk);
    s_valid_a = 1'b0;
    check("t1_count_after_push", fifo_count_a, 1);
    check("t1_strobe_not_yet",   strobe_a,     0);
    @(negedge clk);
    check("t1_first_strobe",  strobe_a,     1);
    check("t1_first_bit",     data_line_a,  1);
    check("t1_count_popped",  fifo_count_a, 0);
    wait_bits_a(8, "t1_timeout");
    repeat (3) @(negedge clk);
    check("t1_bits",       bits_of_a(0, 8), 32'hAF);
    check("t1_strobe_run", run_last_a,      8);
    check("t1_frame_done", fd_cnt_a,        1);
    check("t1_count_end",  fifo_count_a,    0);

    // ---- back-to-back frames ----
    base = bits_a.size();
    @(negedge clk);
    s_data_a  = 7'b1010111;
    s_valid_a = 1'b1;
    @(negedge clk);
    s_data_a  = 7'b0010101;
    @(negedge clk);
    s_valid_a = 1'b0;
    wait_bits_a(base + 16, "t2_timeout");
    repeat (3) @(negedge clk);
    check("t2_frame1",     bits_of_a(base, 8),     32'hAF);
    check("t2_frame2",     bits_of_a(base + 8, 8), 32'h2B);
    check("t2_gap",        gap_a,                  1);
    check("t2_strobe_run", run_last_a,             8);
    check("t2_frame_done", fd_cnt_a,               3);

    // ---- full FIFO: s_valid held, six words offered ----
    base     = bits_a.size();
    k        = 0;
    guard    = 0;
    saw_full = 1'b0;
    ready_at_full = 1'b1;
    @(negedge clk);
    s_data_a  = w[0];
    s_valid_a = 1'b1;
    while (k < 6 && guard < 300) begin
      if (fifo_count_a == 3'd4 && !saw_full) begin
        saw_full      = 1'b1;
        ready_at_full = s_ready_a;
      end
      acc = s_ready_a;
      @(negedge clk);
      guard++;
      if (acc) begin
        k++;
        if (k < 6) s_data_a = w[k];
      end
    end
    s_valid_a = 1'b0;
    check("t3_all_accepted", k, 6);
    check("t3_saw_full",     saw_full,      1);
    check("t3_ready_full",   ready_at_full, 0);
    check("t3_max_count",    max_cnt_a,     4);
    wait_bits_a(base + 48, "t3_timeout");
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++)
      check($sformatf("t3_frame%0d", i), bits_of_a(base + 8*i, 8), 32'(wf[i]));
    check("t3_extra_bits", bits_a.size(), base + 48);
    check("t3_count_end",  fifo_count_a,  0);

    // ---- simultaneous push and pop with two words queued ----
    base = bits_a.size();
    @(negedge clk);
    s_data_a  = w[0];
    s_valid_a = 1'b1;
    @(negedge clk);
    s_data_a  = w[1];
    @(negedge clk);
    s_data_a  = w[2];
    @(negedge clk);
    s_valid_a = 1'b0;
    check("t6_count_before", fifo_count_a, 2);
    guard = 0;
    while (frame_done_a !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("t6_done_seen",    frame_done_a, 1);
    check("t6_count_at_gap", fifo_count_a, 2);
    s_data_a  = w[4];
    s_valid_a = 1'b1;
    @(negedge clk);
    s_valid_a = 1'b0;
    check("t6_count_same", fifo_count_a, 2);
    check("t6_next_frame", strobe_a,     1);
    wait_bits_a(base + 32, "t6_timeout");
    repeat (3) @(negedge clk);
    check("t6_frame0", bits_of_a(base,      8), 32'(wf[0]));
    check("t6_frame1", bits_of_a(base + 8,  8), 32'(wf[1]));
    check("t6_frame2", bits_of_a(base + 16, 8), 32'(wf[2]));
    check("t6_frame3", bits_of_a(base + 24, 8), 32'(wf[4]));

    // ---- reset during bit 3 with two words queued ----
    base      = bits_a.size();
    fd_before = fd_cnt_a;
    @(negedge clk);
    s_data_a  = 7'b1111111;
    s_valid_a = 1'b1;
    @(negedge clk);
    s_data_a  = w[0];
    @(negedge clk);
    s_data_a  = w[1];
    @(negedge clk);
    s_valid_a = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_pre_strobe", strobe_a,     1);
    check("t4_pre_data",   data_line_a,  1);
    check("t4_pre_count",  fifo_count_a, 2);
    #2 rst = 1'b1;
    #1;
    check("t4_strobe",     strobe_a,     0);
    check("t4_data_line",  data_line_a,  0);
    check("t4_count",      fifo_count_a, 0);
    check("t4_s_ready",    s_ready_a,    1);
    check("t4_frame_done", frame_done_a, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("t4_bits_stopped", bits_a.size(), base + 4);
    check("t4_no_done",      fd_cnt_a,      fd_before);
    check("t4_idle_strobe",  strobe_a,      0);
    check("t4_idle_count",   fifo_count_a,  0);

    // ---- alternative configuration: A5 then 01, LSB first, odd parity ----
    base = bits_b.size();
    @(negedge clk);
    s_data_b  = 8'hA5;
    s_valid_b = 1'b1;
    @(negedge clk);
    s_data_b  = 8'h01;
    @(negedge clk);
    s_valid_b = 1'b0;
    wait_bits_b(base + 18, "t5_timeout");
    repeat (5) @(negedge clk);
    check("t5_frame_a5", bits_of_b(base,     9), 32'b1_0100_1011);
    check("t5_frame_01", bits_of_b(base + 9, 9), 32'b1_0000_0000);
    check("t5_gap",      gap_b,        3);
    check("t5_done_cnt", fd_cnt_b,     2);
    check("t5_count",    fifo_count_b, 0);

    check("fd_alignment", fd_bad_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/strobe_serial_tx.md
# strobe_serial_tx

Parametrised serial transmitter for the strobe-qualified one-wire data link. It accepts parallel words through a valid/ready handshake and buffers them in a small FIFO. Each word goes out as a serial frame on `data_line`, with `strobe` marking every valid bit. The frame can carry a parity bit, the bit order is selectable, and frames are separated by enforced idle gaps. The block replaces the fixed 7-bit sender and feeds the matching strobe-framed receiver.

## Interface
- `WIDTH`, 7: data bits per frame (≥1).
- `DEPTH`, 4: FIFO depth in words (power of two, ≥2).
- `PARITY_EN`, 1: when set to 1, a parity bit is appended after the data bits.
- `ODD_PARITY`, 0: 0 selects even parity, 1 selects odd.
- `MSB_FIRST`, 1: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
- `GAP`, 1: minimum idle cycles between frames (≥1).

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_data`  in  WIDTH  word to send.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  FIFO can accept a word.
- `data_line`  out  1  serial data.
- `strobe`  out  1  high in every cycle that carries a frame bit.
- `frame_done`  out  1  one-cycle pulse after the last bit of a frame.
- `fifo_count`  out  $clog2(DEPTH+1)  words currently buffered.

## Operation
- **Push**
  - A word is accepted on a rising edge when `s_valid && s_ready`.
  - `s_ready = (fifo_count != DEPTH)`.
  - If the FIFO is full, `s_valid` is ignored: no overflow and no data loss.
- **FSM states:** IDLE, SHIFT, PARITY, GAP.
- **IDLE**
  - `strobe=0`, `data_line=0`.
  - If the FIFO is non-empty: pop the head into the shift register, drive the first bit, set `strobe=1`, and go to SHIFT.
- **SHIFT**
  - Drives WIDTH bits, one per cycle, in the order set by `MSB_FIRST`.
  - A bit counter runs 0..WIDTH-1.
  - After the last bit, go to PARITY if `PARITY_EN`, otherwise go to GAP.
- **PARITY**
  - One cycle with `strobe=1`.
  - `data_line` = XOR of all data bits, XOR `ODD_PARITY`.
- **GAP**
  - GAP cycles with `strobe=0` and `data_line=0`.
  - `frame_done=1` in the first GAP cycle only.
  - At the end of the last GAP cycle: if the FIFO is non-empty, pop and go straight to SHIFT; otherwise go to IDLE.
- **Outputs**
  - `data_line`, `strobe` and `frame_done` are registered; there are no combinational paths from inputs to them.
- **Simultaneous push and pop:** `fifo_count` is unchanged and the data order is preserved (strict FIFO).
- **Reset**
  - While `rst=1`, asynchronously: FSM=IDLE, FIFO emptied, `fifo_count=0`, `s_ready=1`, `data_line=0`, `strobe=0`, `frame_done=0`.
  - A reset mid-frame aborts the frame. `strobe` falls at once, and no `frame_done` pulse is produced for the aborted frame.
- **FIFO pointers:** $clog2(DEPTH) bits wide and wrap naturally.

## Timing
- **Latency:** a word accepted at edge N into an empty, IDLE block has its first bit with `strobe=1` registered at edge N+1.
- **Frame period** (back-to-back, FIFO never empty): WIDTH + `PARITY_EN` + GAP cycles.
- **Strobe shape:** `strobe` is high for exactly WIDTH + `PARITY_EN` consecutive cycles per frame, then low for at least GAP cycles.
- **Ready timing:** `s_ready` is updated combinationally from the registered count, so a pop at edge N frees a slot visible in cycle N+1.
- **Throughput:** sustained input rate is at most 1 word per frame period; the FIFO absorbs bursts of up to DEPTH words.

## Structure
- **Package `strobe_link_pkg`:**
  - FSM state typedef (IDLE, SHIFT, PARITY, GAP).
  - Default WIDTH and GAP constants.
  - A parity function shared with the receiver.
- **Sub-module `sync_fifo`:**
  - Parameters WIDTH and DEPTH.
  - Ports: push, pop, full, empty, count.
  - Asynchronous active-high reset.
- **Top level:** FSM, bit counter, gap counter, shift register and output registers.

## Test plan
- **Single frame, defaults.**
  - Stimulus: reset for 10 ns, then push 7'b1010111.
  - Required: `strobe` high for 8 cycles; `data_line` sequence 1,0,1,0,1,1,1, then parity 1; `frame_done` pulse in the next cycle; `fifo_count` returns to 0.
- **Back-to-back frames.**
  - Stimulus: push 7'b1010111 and 7'b0010101 on consecutive edges.
  - Required: second frame 0,0,1,0,1,0,1, parity 1; exactly 1 strobe-low cycle between the frames.
- **Full FIFO.**
  - Stimulus: hold `s_valid=1` with DEPTH=4 while the first frame is shifting.
  - Required: `s_ready` drops when `fifo_count`=4; no word is lost or duplicated; all 5 words are sent in order.
- **Mid-frame reset.**
  - Stimulus: assert `rst` during bit 3 of a frame with 2 words queued.
  - Required: `strobe` and `data_line` go to 0 immediately; `fifo_count`=0; no `frame_done`; after release the link stays IDLE.
- **Alternative configuration.**
  - Parameters: WIDTH=8, MSB_FIRST=0, ODD_PARITY=1, GAP=3.
  - Stimulus: push 8'hA5.
  - Required: bits 1,0,1,0,0,1,0,1, then parity 1; then 3 idle cycles before the next frame.
- **Simultaneous push and pop.**
  - Stimulus: push exactly on the edge the FSM pops, with `fifo_count`=2.
  - Required: `fifo_count` stays 2; output order is preserved.
